mouse_ctrl: RTL and testbench
=============================

// Module: mouse_ctrl
// PURPOSE
//  Sequences a PS/2 mouse for the sand game. Runs the power-up command handshake
//  (reset, then enable streaming) through a byte-level PS/2 TX/RX PHY.
//  Assembles 3-byte movement packets and accumulates a clamped on-screen cursor.
//  Cursor and buttons drive the sand-painting logic; done_o flags each cursor update.
// PARAMETERS
//  SCREEN_W        320    cursor x range 0..SCREEN_W-1 (max 512)
//  SCREEN_H        240    cursor y range 0..SCREEN_H-1 (max 512)
//  X_INIT          160    cursor x after reset
//  Y_INIT          120    cursor y after reset
//  TIMEOUT_CYCLES  2000000  watchdog limit in clk_i cycles (used only with MOUSE_TIMEOUT_EN)
// PORTS
//  clk_i        in   1  system clock; sole clock domain
//  reset_i      in   1  synchronous, active-high reset
//  rx_data_i    in   8  byte received from the PS/2 PHY
//  rx_valid_i   in   1  one-cycle strobe; rx_data_i valid
//  tx_data_o    out  8  command byte to the PHY
//  tx_req_o     out  1  transmit request; held until tx_ack_i
//  tx_ack_i     in   1  one-cycle strobe; PHY finished sending tx_data_o
//  x_o          out  9  cursor x, unsigned
//  y_o          out  9  cursor y, unsigned; 0 = top of screen
//  btn_o        out  3  {middle, right, left}, 1 = pressed
//  done_o       out  1  one-cycle pulse: new packet applied to x_o/y_o/btn_o
//  init_ok_o    out  1  high while in STREAM
// BEHAVIOUR
//  Reset values: x_o=X_INIT, y_o=Y_INIT, btn_o=0, done_o=0, tx_req_o=0, tx_data_o=0,
//   init_ok_o=0, state=SEND_RST, byte_idx=0.
//  Reset mid-operation: all state is dropped at that clock edge, including tx_req_o.
//  TX handshake:
//   - In SEND_* states, drive tx_data_o and set tx_req_o=1 on the cycle after entry.
//   - tx_data_o stays stable until tx_ack_i is sampled high.
//   - The next cycle after tx_ack_i: tx_req_o=0 and the matching WAIT state is entered.
//  rx_valid_i is ignored in SEND_* states (half-duplex bus); the byte is dropped.
//  FSM:
//   SEND_RST   tx 0xFF -> WAIT_ACK1
//   WAIT_ACK1  rx 0xFA -> WAIT_BAT; 0xFE -> SEND_RST; other byte -> SEND_RST
//   WAIT_BAT   rx 0xAA -> WAIT_ID; other byte -> SEND_RST
//   WAIT_ID    rx 0x00 -> SEND_EN; other byte -> SEND_RST
//   SEND_EN    tx 0xF4 -> WAIT_ACK2
//   WAIT_ACK2  rx 0xFA -> STREAM; 0xFE -> SEND_EN; other byte -> SEND_RST
//   STREAM     packet assembly; never leaves except on reset
//  Packet assembly in STREAM (byte_idx counts 0,1,2 then wraps to 0):
//   - byte0 = {yov, xov, ysgn, xsgn, 1, M, R, L}; byte1 = dx[7:0]; byte2 = dy[7:0].
//   - At byte_idx=0 a byte with bit3=0 is discarded and byte_idx stays 0 (resync).
//  Update rule when byte2 arrives at cycle N, applied at edge N+1 together with done_o=1:
//   - dx = {xsgn, byte1} and dy = {ysgn, byte2} are 9-bit two's complement.
//   - Compute in 11-bit signed: nx = x + dx; ny = y - dy (PS/2 +y is up).
//   - Clamp nx to 0..SCREEN_W-1 and ny to 0..SCREEN_H-1 (min and max edges both).
//   - xov=1 leaves x unchanged; yov=1 leaves y unchanged.
//   - btn_o always takes {M, R, L} from byte0.
//  done_o is high for exactly one cycle per accepted packet; it is never high outside STREAM.
//  Back-to-back packets: done_o may pulse every 3 rx strobes; nothing is lost.
// CONFIGURATION
//  MOUSE_TIMEOUT_EN defined:
//   - A counter resets on every state change and every accepted rx byte.
//   - In a WAIT_* state, reaching TIMEOUT_CYCLES forces SEND_RST.
//   - In a SEND_* state, reaching TIMEOUT_CYCLES without tx_ack_i also forces SEND_RST.
//   - In STREAM with byte_idx!=0, reaching TIMEOUT_CYCLES sets byte_idx=0 and drops the partial packet.
//  MOUSE_TIMEOUT_EN undefined: no counter is built; WAIT and SEND states wait indefinitely.
// TESTING
//  1. Release reset; ack tx 0xFF; rx FA, AA, 00; ack tx 0xF4; rx FA ->
//     init_ok_o=1, tx_req_o=0.
//  2. STREAM, x=160, y=120; rx 08,05,03 -> at N+1 done_o=1, x_o=165, y_o=117, btn_o=0.
//  3. x=2; rx 19,F0,00 (dx=-16, L pressed) -> x_o=0, btn_o=3'b001.
//     Then rx 08,7F,00 repeated until saturation -> x_o=319.
//  4. rx 00 (bit3=0), then 08,01,00 -> exactly one done_o pulse, x_o incremented by 1.
//  5. During WAIT_ACK1 rx FE -> tx_req_o reasserts with 0xFF.
//     During WAIT_ACK2 rx FE -> tx_req_o reasserts with 0xF4.
//  6. reset_i=1 mid-packet (byte_idx=2) -> next cycle outputs at reset values, tx_req_o=0.
//     With MOUSE_TIMEOUT_EN and TIMEOUT_CYCLES=50: idle WAIT_BAT 50 cycles -> tx 0xFF again.

Source files
------------

// File: rtl/mouse_ctrl.sv
// mouse_ctrl: PS/2 mouse power-up handshake, 3-byte packet assembly and clamped cursor tracking.
// Optional watchdog is built only when MOUSE_TIMEOUT_EN is defined.
module mouse_ctrl #(
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 240,
   parameter int unsigned X_INIT   = 160,
   parameter int unsigned Y_INIT   = 120
`ifdef MOUSE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic [7:0] tx_data_o,
   output logic       tx_req_o,
   input  logic       tx_ack_i,
   output logic [8:0] x_o,
   output logic [8:0] y_o,
   output logic [2:0] btn_o,
   output logic       done_o,
   output logic       init_ok_o
);

   typedef enum logic [2:0] {
      StSendRst,
      StWaitAck1,
      StWaitBat,
      StWaitId,
      StSendEn,
      StWaitAck2,
      StStream
   } state_e;

   localparam logic signed [10:0] XMax = 11'(SCREEN_W - 1);
   localparam logic signed [10:0] YMax = 11'(SCREEN_H - 1);

   state_e     state_q;
   logic [1:0] byte_idx_q;
   // Header without the always-one bit: {yov, xov, ysgn, xsgn, M, R, L}
   logic [6:0] hdr_q;
   logic [7:0] dx_lo_q;
   logic [8:0] x_q, y_q;
   logic [2:0] btn_q;
   logic       done_q;
   logic       tx_req_q;
   logic [7:0] tx_data_q;

   logic              in_send, rx_acc, tx_done, timeout;
   logic signed [10:0] nx, ny;
   logic [8:0]        x_next, y_next;

   always_comb begin
      in_send = (state_q == StSendRst) || (state_q == StSendEn);
      rx_acc  = rx_valid_i && !in_send;
      tx_done = in_send && tx_req_q && tx_ack_i;
   end

   // Cursor arithmetic: byte2 is taken straight from the bus so the update lands on the next edge.
   always_comb begin
      nx     = $signed({2'b00, x_q}) + $signed({{2{hdr_q[3]}}, hdr_q[3], dx_lo_q});
      ny     = $signed({2'b00, y_q}) - $signed({{3{hdr_q[4]}}, rx_data_i});
      x_next = x_q;
      y_next = y_q;
      if (!hdr_q[5]) begin
         if (nx < 0) begin
            x_next = '0;
         end else if (nx > XMax) begin
            x_next = XMax[8:0];
         end else begin
            x_next = nx[8:0];
         end
      end
      if (!hdr_q[6]) begin
         if (ny < 0) begin
            y_next = '0;
         end else if (ny > YMax) begin
            y_next = YMax[8:0];
         end else begin
            y_next = ny[8:0];
         end
      end
   end

`ifdef MOUSE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] tmo_cnt_q;
   logic            tmo_armed;

   // Every state change happens on rx_acc, tx_done or timeout, so those clear the counter.
   always_comb begin
      tmo_armed = (state_q != StStream) || (byte_idx_q != 2'd0);
      timeout   = tmo_armed && !rx_acc && !tx_done && (tmo_cnt_q >= CntLast);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || rx_acc || tx_done || timeout) begin
         tmo_cnt_q <= '0;
      end else if (tmo_cnt_q < CntLast) begin
         tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StSendRst;
         byte_idx_q <= '0;
         hdr_q      <= '0;
         dx_lo_q    <= '0;
         x_q        <= 9'(X_INIT);
         y_q        <= 9'(Y_INIT);
         btn_q      <= '0;
         done_q     <= 1'b0;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (timeout) begin
            if (state_q == StStream) begin
               byte_idx_q <= '0;
            end else begin
               state_q  <= StSendRst;
               tx_req_q <= 1'b0;
            end
         end else begin
            case (state_q)
               StSendRst, StSendEn: begin
                  if (tx_done) begin
                     tx_req_q <= 1'b0;
                     if (state_q == StSendRst) begin
                        state_q <= StWaitAck1;
                     end else begin
                        state_q <= StWaitAck2;
                     end
                  end else begin
                     tx_req_q  <= 1'b1;
                     tx_data_q <= (state_q == StSendRst) ? 8'hFF : 8'hF4;
                  end
               end
               StWaitAck1: begin
                  if (rx_valid_i) begin
                     state_q <= (rx_data_i == 8'hFA) ? StWaitBat : StSendRst;
                  end
               end
               StWaitBat: begin
                  if (rx_valid_i) begin
                     state_q <= (rx_data_i == 8'hAA) ? StWaitId : StSendRst;
                  end
               end
               StWaitId: begin
                  if (rx_valid_i) begin
                     state_q <= (rx_data_i == 8'h00) ? StSendEn : StSendRst;
                  end
               end
               StWaitAck2: begin
                  if (rx_valid_i) begin
                     if (rx_data_i == 8'hFA) begin
                        state_q <= StStream;
                     end else if (rx_data_i == 8'hFE) begin
                        state_q <= StSendEn;
                     end else begin
                        state_q <= StSendRst;
                     end
                  end
               end
               StStream: begin
                  if (rx_valid_i) begin
                     case (byte_idx_q)
                        2'd0: begin
                           // Bit 3 of a header is always set; anything else means we lost sync.
                           if (rx_data_i[3]) begin
                              hdr_q      <= {rx_data_i[7:4], rx_data_i[2:0]};
                              byte_idx_q <= 2'd1;
                           end
                        end
                        2'd1: begin
                           dx_lo_q    <= rx_data_i;
                           byte_idx_q <= 2'd2;
                        end
                        default: begin
                           x_q        <= x_next;
                           y_q        <= y_next;
                           btn_q      <= hdr_q[2:0];
                           done_q     <= 1'b1;
                           byte_idx_q <= 2'd0;
                        end
                     endcase
                  end
               end
               default: begin
                  state_q <= StSendRst;
               end
            endcase
         end
      end
   end

   assign tx_data_o = tx_data_q;
   assign tx_req_o  = tx_req_q;
   assign x_o       = x_q;
   assign y_o       = y_q;
   assign btn_o     = btn_q;
   assign done_o    = done_q;
   assign init_ok_o = (state_q == StStream);

endmodule

// File: tb/tb_mouse_ctrl.sv
// tb_mouse_ctrl: directed handshake plus random movement packets checked against an
// integer cursor model with min/max clamping.
module tb_mouse_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_ack = 1'b0;
   logic [8:0] x, y;
   logic [2:0] btn;
   logic       done;
   logic       init_ok;

   always #5 clk = ~clk;

   mouse_ctrl dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .rx_data_i (rx_data),
      .rx_valid_i(rx_valid),
      .tx_data_o (tx_data),
      .tx_req_o  (tx_req),
      .tx_ack_i  (tx_ack),
      .x_o       (x),
      .y_o       (y),
      .btn_o     (btn),
      .done_o    (done),
      .init_ok_o (init_ok)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference cursor state
   int         mx = 160;
   int         my = 120;
   logic [2:0] mbtn = 3'b000;

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic serve_tx(input logic [7:0] exp);
      int waited = 0;
      while (tx_req !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check("tx_req asserted", 32'(tx_req), 32'd1);
      check("tx_data", 32'(tx_data), 32'(exp));
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      check("tx_req dropped", 32'(tx_req), 32'd0);
   endtask

   task automatic check_reset_vals();
      check("rst x", 32'(x), 32'd160);
      check("rst y", 32'(y), 32'd120);
      check("rst btn", 32'(btn), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst tx_req", 32'(tx_req), 32'd0);
      check("rst tx_data", 32'(tx_data), 32'd0);
      check("rst init_ok", 32'(init_ok), 32'd0);
   endtask

   task automatic packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy;
      send_rx(b0);
      send_rx(b1);
      check("done early", 32'(done), 32'd0);
      send_rx(b2);
      dx = b0[4] ? int'(b1) - 256 : int'(b1);
      dy = b0[5] ? int'(b2) - 256 : int'(b2);
      if (!b0[6]) mx = clamp(mx + dx, 0, 319);
      if (!b0[7]) my = clamp(my - dy, 0, 239);
      mbtn = b0[2:0];
      check("done pulse", 32'(done), 32'd1);
      check("x", 32'(x), 32'(mx));
      check("y", 32'(y), 32'(my));
      check("btn", 32'(btn), 32'(mbtn));
   endtask

   initial begin
      logic [7:0] r0, r1, r2;

      // Reset state
      step();
      step();
      check_reset_vals();
      reset = 1'b0;

      // Init handshake; rx while sending is dropped, FE re-requests the same command
      send_rx(8'hFA);
      serve_tx(8'hFF);
      send_rx(8'hFE);
      serve_tx(8'hFF);
      send_rx(8'hFA);
      send_rx(8'hAA);
      send_rx(8'h00);
      serve_tx(8'hF4);
      send_rx(8'hFE);
      serve_tx(8'hF4);
      check("init_ok before ack", 32'(init_ok), 32'd0);
      send_rx(8'hFA);
      check("init_ok", 32'(init_ok), 32'd1);
      check("tx_req idle", 32'(tx_req), 32'd0);

      // Basic movement
      packet(8'h08, 8'h05, 8'h03);
      check("x basic", 32'(x), 32'd165);
      check("y basic", 32'(y), 32'd117);
      step();
      check("done one cycle", 32'(done), 32'd0);

      // Left-edge clamp, then right-edge saturation
      packet(8'h18, 8'h5D, 8'h00);
      check("x at 2", 32'(x), 32'd2);
      packet(8'h19, 8'hF0, 8'h00);
      check("x clamp min", 32'(x), 32'd0);
      check("btn left", 32'(btn), 32'd1);
      for (int i = 0; i < 3; i++) packet(8'h08, 8'h7F, 8'h00);
      check("x clamp max", 32'(x), 32'd319);

      // Vertical clamps and overflow flags
      packet(8'h08, 8'h00, 8'h7F);
      packet(8'h08, 8'h00, 8'h7F);
      check("y clamp min", 32'(y), 32'd0);
      packet(8'h28, 8'h00, 8'h01);
      check("y clamp max", 32'(y), 32'd239);
      packet(8'h58, 8'h80, 8'h00);
      packet(8'h8E, 8'h00, 8'h7F);
      packet(8'h18, 8'h00, 8'h00);

      // Resync: a header without bit 3 is discarded
      send_rx(8'h00);
      check("no done on junk", 32'(done), 32'd0);
      packet(8'h08, 8'h01, 8'h00);
      check("x resync", 32'(x), 32'd64);
      step();
      check("single pulse", 32'(done), 32'd0);

      // Random packets, some with junk bytes and idle gaps in front
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) send_rx(8'($urandom) & 8'hF7);
         if ($urandom_range(0, 2) == 0) step();
         r0 = 8'($urandom) | 8'h08;
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         packet(r0, r1, r2);
      end

      // Reset in the middle of a packet
      send_rx(8'h08);
      send_rx(8'h10);
      reset = 1'b1;
      step();
      check_reset_vals();
      reset = 1'b0;
      serve_tx(8'hFF);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
